alu_seq: RTL



---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, result and flags out,
// each direction under its own valid/ready handshake.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, a, b, aluop, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, a, b, aluop, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result: single-cycle logic/arith/shift/compare ops plus
// bit-serial multiply (shift-add) and restoring unsigned divide taking WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH:0]   mul_add_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_sub_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [WIDTH-1:0] alu_res_s;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [SHW-1:0] sh;
        sh = y[SHW-1:0];
        case (op)
            4'b0000: alu_fn = x + y;
            4'b0010: alu_fn = x - y;
            4'b0100: alu_fn = x & y;
            4'b0101: alu_fn = x | y;
            4'b0110: alu_fn = x ^ y;
            4'b0111: alu_fn = ~(x | y);
            4'b1010: alu_fn = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            4'b1000: alu_fn = {{(WIDTH-1){1'b0}}, (x < y)};
            4'b0001: alu_fn = x << sh;
            4'b0011: alu_fn = x >> sh;
            4'b1011: alu_fn = $signed(x) >>> sh;
            default: alu_fn = ZERO_W;
        endcase
    endfunction

    assign in_ready_s = rst_n & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept_s   = bus.in_valid & in_ready_s;
    assign alu_res_s  = alu_fn(bus.aluop, bus.a, bus.b);

    // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_add_s   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    assign div_shift_s = {hi_q, lo_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    assign div_sub_s   = div_shift_s - {1'b0, opnd_q};
    assign step_hi_s   = op_q[1] ? (div_ge_s ? div_sub_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0])
                                 : mul_add_s[WIDTH:1];
    assign step_lo_s   = op_q[1] ? {lo_q[WIDTH-2:0], div_ge_s}
                                 : {mul_add_s[0], lo_q[WIDTH-1:1]};

    // Next-state, iteration and result-register update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    result_d  = op_q[0] ? step_hi_s : step_lo_s;
                    zero_d    = ((op_q[0] ? step_hi_s : step_lo_s) == ZERO_W);
                    illegal_d = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_s) begin
            if (bus.aluop[3:2] == 2'b11) begin
                state_d = BUSY;
                cnt_d   = CW'(WIDTH);
                op_d    = bus.aluop[1:0];
                hi_d    = ZERO_W;
                lo_d    = bus.aluop[1] ? bus.a : bus.b;
                opnd_d  = bus.aluop[1] ? bus.b : bus.a;
            end else begin
                state_d   = DONE;
                result_d  = alu_res_s;
                zero_d    = (alu_res_s == ZERO_W);
                illegal_d = (bus.aluop == 4'b1001);
            end
        end else begin
            op_d = op_d;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            opnd_q    <= ZERO_W;
            op_q      <= 2'b00;
            result_q  <= ZERO_W;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule
